// File: rtl/makina_pkg.sv
//------------------------------------------------------------------------------
// makina_pkg
// Shared widths, opcode/jump-condition encodings and the fetch entry type.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package makina_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [1:0] OPC_MEM = 2'b00;
  localparam logic [1:0] OPC_ALU = 2'b01;
  localparam logic [1:0] OPC_JMP = 2'b10;

  localparam logic [2:0] JC_NOP = 3'b111;
  localparam logic [2:0] JC_JMP = 3'b110;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Jump class that is not a jump-NOP.
  function automatic logic is_ctrl_instr(input logic [INSTR_W-1:0] instr);
    return (instr[15:14] == OPC_JMP) && (instr[13:11] != JC_NOP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of fetch entries with a registered, sticky head output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import makina_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  fetch_entry_t     r_head;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_do_pop;
  logic             w_do_push;
  logic [CNT_W-1:0] w_keep;
  logic [PTR_W-1:0] w_rd_next;
  fetch_entry_t     w_head_nxt;

  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ~clear & ((r_count != FULL_CNT) | w_do_pop);
  assign w_keep    = r_count - CNT_W'(w_do_pop);
  assign w_rd_next = r_rd_ptr + PTR_W'(w_do_pop);

  // The head is its own register so it holds its last value once the queue
  // drains or is cleared, instead of exposing a stale array slot.
  always_comb begin
    w_head_nxt = r_head;
    if (!clear) begin
      if (w_keep != '0) begin
        w_head_nxt = r_mem[w_rd_next];
      end else if (w_do_push) begin
        w_head_nxt = push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (clear) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) begin
          r_mem[r_wr_ptr] <= push_data;
          r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
        r_rd_ptr <= w_rd_next;
        r_count  <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
    end
  end

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_head;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// instr_fetch
// Fetch PC, program memory request, prefetch queue and control-flow pre-flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch
  import makina_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_is_ctrl,
  output logic [7:0]         flush_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_fpc;
  logic [7:0]        r_flush_count;

  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic              w_unused_count;
  fetch_entry_t      w_push_data;
  fetch_entry_t      w_head;

  assign w_pop    = out_valid & out_ready;
  assign imem_req = rst_n & ~redirect_valid & (~w_full | w_pop);

  // Reset shows RESET_PC immediately rather than waiting for the first edge.
  assign imem_addr = rst_n ? r_fpc : RESET_PC;

  assign w_push_data.pc    = r_fpc;
  assign w_push_data.instr = imem_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fpc         <= RESET_PC;
      r_flush_count <= '0;
    end else if (redirect_valid) begin
      r_fpc <= redirect_pc;
      if (r_flush_count != 8'hFF) begin
        r_flush_count <= r_flush_count + 8'd1;
      end
    end else if (imem_req) begin
      r_fpc <= r_fpc + ADDR_W'(1);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (imem_req),
    .push_data (w_push_data),
    .pop       (w_pop),
    .clear     (redirect_valid),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (w_head)
  );

  assign w_unused_count = &{1'b0, w_count};

  assign out_valid   = ~w_empty;
  assign out_pc      = w_head.pc;
  assign out_instr   = w_head.instr;
  assign out_is_ctrl = is_ctrl_instr(w_head.instr);
  assign flush_count = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//------------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch with an expected-PC scoreboard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic        out_is_ctrl;
  logic [7:0]  flush_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] sb[$];

  instr_fetch #(
    .RESET_PC (16'h0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_is_ctrl    (out_is_ctrl),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_of(input logic [15:0] a);
    case (a)
      16'h0100: return 16'h9800;
      16'h0101: return 16'hB800;
      16'h0102: return 16'h4000;
      default:  return 16'h4000 + a;
    endcase
  endfunction

  function automatic logic model_ctrl(input logic [15:0] i);
    return (i[15:14] == 2'b10) && (i[13:11] != 3'b111);
  endfunction

  always_comb imem_data = mem_of(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop at the falling edge, where the coming handshake is stable.
  task automatic cycle();
    logic [15:0] exp_pc;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_pop: observed pc %h expected no output", out_pc);
      end
      if (sb.size() != 0) begin
        exp_pc = sb.pop_front();
        check("pop_pc", {16'h0, out_pc}, {16'h0, exp_pc});
        check("pop_instr", {16'h0, out_instr}, {16'h0, mem_of(exp_pc)});
        check("pop_is_ctrl", {31'h0, out_is_ctrl}, {31'h0, model_ctrl(mem_of(exp_pc))});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    sb.delete();
    cycle();
    cycle();
  endtask

  initial begin
    do_reset();
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_pc", {16'h0, out_pc}, 32'h0);
    check("rst_instr", {16'h0, out_instr}, 32'h0);
    check("rst_is_ctrl", {31'h0, out_is_ctrl}, 32'h0);
    check("rst_flush", {24'h0, flush_count}, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", {16'h0, imem_addr}, 32'h0);

    // Streaming with decode always ready.
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back(16'(i));
    cycle();
    check("stream_latency_valid", {31'h0, out_valid}, 32'h1);
    check("stream_first_pc", {16'h0, out_pc}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("stream_no_gap", {31'h0, out_valid}, 32'h1);
      cycle();
    end
    out_ready = 1'b0;
    check("stream_drained", sb.size(), 32'h0);

    // Backpressure.
    do_reset();
    rst_n = 1'b1;
    repeat (5) cycle();
    check("bp_req", {31'h0, imem_req}, 32'h0);
    check("bp_fpc", {16'h0, imem_addr}, 32'h2);
    check("bp_head_pc", {16'h0, out_pc}, 32'h0);
    check("bp_valid", {31'h0, out_valid}, 32'h1);
    for (int i = 0; i < 4; i++) sb.push_back(16'(i));
    out_ready = 1'b1;
    #1;
    check("bp_req_on_pop", {31'h0, imem_req}, 32'h1);
    repeat (4) cycle();
    out_ready = 1'b0;
    check("bp_drained", sb.size(), 32'h0);

    // Redirect while full with a same-cycle pop.
    do_reset();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) sb.push_back(16'(i));
    repeat (6) cycle();
    out_ready = 1'b0;
    repeat (2) cycle();
    check("rd_head_pc", {16'h0, out_pc}, 32'h5);
    check("rd_full_req", {31'h0, imem_req}, 32'h0);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    #1;
    check("rd_req_blocked", {31'h0, imem_req}, 32'h0);
    cycle();
    redirect_valid = 1'b0;
    check("rd_flush", {24'h0, flush_count}, 32'h1);
    check("rd_cleared", {31'h0, out_valid}, 32'h0);
    sb.push_back(16'h0040);
    sb.push_back(16'h0041);
    cycle();
    check("rd_target_valid", {31'h0, out_valid}, 32'h1);
    check("rd_target_pc", {16'h0, out_pc}, 32'h40);
    repeat (2) cycle();
    out_ready = 1'b0;
    check("rd_drained", sb.size(), 32'h0);

    // Wrap-around of the fetch PC.
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    cycle();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    sb.push_back(16'hFFFE);
    sb.push_back(16'hFFFF);
    sb.push_back(16'h0000);
    sb.push_back(16'h0001);
    repeat (5) cycle();
    out_ready = 1'b0;
    check("wrap_drained", sb.size(), 32'h0);
    check("wrap_flush", {24'h0, flush_count}, 32'h2);

    // Pre-decode of control-flow instructions.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check("pd_head_pc", {16'h0, out_pc}, 32'h100);
    check("pd_head_ctrl", {31'h0, out_is_ctrl}, 32'h1);
    sb.push_back(16'h0100);
    sb.push_back(16'h0101);
    sb.push_back(16'h0102);
    out_ready = 1'b1;
    repeat (3) cycle();
    out_ready = 1'b0;
    check("pd_drained", sb.size(), 32'h0);
    check("pd_last_ctrl", {31'h0, out_is_ctrl}, 32'h0);

    // Saturation of the redirect counter (starts at 3).
    redirect_valid = 1'b1;
    repeat (251) cycle();
    check("sat_fe", {24'h0, flush_count}, 32'hFE);
    repeat (49) cycle();
    check("sat_ff", {24'h0, flush_count}, 32'hFF);
    redirect_valid = 1'b0;

    // Reset mid-stream wins over a redirect.
    repeat (2) cycle();
    check("mr_queued", {31'h0, out_valid}, 32'h1);
    check("mr_full", {31'h0, imem_req}, 32'h0);
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0500;
    cycle();
    check("mr_valid", {31'h0, out_valid}, 32'h0);
    check("mr_flush", {24'h0, flush_count}, 32'h0);
    check("mr_addr", {16'h0, imem_addr}, 32'h0);
    check("mr_pc", {16'h0, out_pc}, 32'h0);
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    sb.push_back(16'h0000);
    sb.push_back(16'h0001);
    sb.push_back(16'h0002);
    repeat (4) cycle();
    out_ready = 1'b0;
    check("mr_drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
